// File: rtl/imsic_msi_wr_buffer.sv
// Buffered IMSIC MSI write decoder: bus writes -> (hart, file, identity) FIFO -> per-hart setipnum strobes.
// Optional feature: define IMSIC_MSI_BE_EN to decode page offset 0x004 as byte-swapped seteipnum_be.
module imsic_msi_wr_buffer #(
  parameter int                NR_HARTS   = 4,
  parameter int                NR_FILES   = 2,
  parameter int                NR_SRC     = 64,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] M_BASE     = ADDR_W'(32'h2400_0000),
  parameter logic [ADDR_W-1:0] S_BASE     = ADDR_W'(32'h2800_0000),
  parameter int                FIFO_DEPTH = 4,
  localparam int               NR_SRC_W   = $clog2(NR_SRC)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [ADDR_W-1:0]              i_req_addr,
  input  logic [31:0]                    i_req_data,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_err,
  input  logic [NR_HARTS-1:0]            i_file_busy,
  output logic [NR_HARTS*NR_SRC_W-1:0]   o_setipnum,
  output logic [NR_HARTS*NR_FILES-1:0]   o_setipnum_we,
  output logic [15:0]                    o_drop_cnt
);

  localparam int HART_W = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
  localparam int FILE_W = (NR_FILES > 1) ? $clog2(NR_FILES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PG_W   = ADDR_W - 12;
  localparam int S_DIV  = (NR_FILES > 1) ? NR_FILES - 1 : 1;

  localparam logic [ADDR_W:0]   M_SIZE  = (ADDR_W+1)'(NR_HARTS) << 12;
  localparam logic [ADDR_W:0]   S_SIZE  = (ADDR_W+1)'(NR_HARTS * (NR_FILES - 1)) << 12;
  localparam logic [PG_W-1:0]   S_DIV_V = PG_W'(S_DIV);
  localparam logic [PTR_W:0]    FULL_V  = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [HART_W-1:0]   h;
    logic [FILE_W-1:0]   f;
    logic [NR_SRC_W-1:0] id;
  } msi_t;

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] w_m_off;
  logic [ADDR_W-1:0] w_s_off;
  logic              w_hit_m;
  logic              w_hit_s;
  logic              w_hit;
  logic [PG_W-1:0]   w_m_page;
  logic [PG_W-1:0]   w_s_page;
  logic [PG_W-1:0]   w_s_hq;
  logic [PG_W-1:0]   w_s_fr;
  logic [HART_W-1:0] w_dec_h;
  logic [FILE_W-1:0] w_dec_f;
  logic [11:0]       w_pg_off;
  logic              w_le_sel;
  logic              w_be_sel;
  logic [31:0]       w_ident;
  logic              w_id_sel;
  logic              w_id_ok;
  logic              w_unused;

  assign w_m_off  = i_req_addr - M_BASE;
  assign w_s_off  = i_req_addr - S_BASE;
  assign w_hit_m  = (i_req_addr >= M_BASE) && ({1'b0, w_m_off} < M_SIZE);
  assign w_hit_s  = (NR_FILES > 1) && (i_req_addr >= S_BASE) && ({1'b0, w_s_off} < S_SIZE);
  assign w_hit    = w_hit_m || w_hit_s;
  assign w_m_page = w_m_off[ADDR_W-1:12];
  assign w_s_page = w_s_off[ADDR_W-1:12];
  assign w_s_hq   = w_s_page / S_DIV_V;
  assign w_s_fr   = w_s_page % S_DIV_V;
  assign w_unused = ^{w_m_page, w_s_hq, w_s_fr};

  // M pages win if a parameterisation ever makes the two windows overlap.
  always_comb begin
    w_dec_h = '0;
    w_dec_f = '0;
    if (w_hit_m) begin
      w_dec_h = w_m_page[HART_W-1:0];
      w_dec_f = '0;
    end else begin
      w_dec_h = w_s_hq[HART_W-1:0];
      w_dec_f = w_s_fr[FILE_W-1:0] + FILE_W'(1);
    end
  end

  assign w_pg_off = i_req_addr[11:0];
  assign w_le_sel = (w_pg_off == 12'h000);

`ifdef IMSIC_MSI_BE_EN
  assign w_be_sel = (w_pg_off == 12'h004);
  assign w_ident  = w_be_sel ? {i_req_data[7:0], i_req_data[15:8],
                                i_req_data[23:16], i_req_data[31:24]}
                             : i_req_data;
`else
  assign w_be_sel = 1'b0;
  assign w_ident  = i_req_data;
`endif

  assign w_id_sel = w_hit && (w_le_sel || w_be_sel);
  assign w_id_ok  = (w_ident != 32'd0) && (w_ident < 32'(NR_SRC));

  // ---------------------------------------------------------------- handshake
  // Request: transfer when i_req_valid && o_req_ready at a rising edge; ready
  // depends only on registered state (and reset), never on i_req_valid.
  // Response: o_rsp_valid stays high until i_rsp_ready is sampled high; only
  // one response may be outstanding, so no new request is taken meanwhile.
  logic             r_rsp_pending;
  logic             r_rsp_err;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  msi_t             w_head;
  msi_t             r_mem [FIFO_DEPTH];

  assign w_full      = (r_count == FULL_V);
  assign w_empty     = (r_count == '0);
  assign w_req_ready = !i_rst && !r_rsp_pending && !w_full;
  assign w_accept    = i_req_valid && w_req_ready;
  assign w_push      = w_accept && w_id_sel && w_id_ok;
  assign w_drop      = w_accept && w_id_sel && !w_id_ok;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_pop       = !w_empty && !i_file_busy[w_head.h];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_pending <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else if (w_accept) begin
      r_rsp_pending <= 1'b1;
      r_rsp_err     <= !w_hit;
    end else if (r_rsp_pending && i_rsp_ready) begin
      r_rsp_pending <= 1'b0;
      r_rsp_err     <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- fifo
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{h: w_dec_h, f: w_dec_f, id: w_ident[NR_SRC_W-1:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- drop counter
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- drain outputs
  logic [NR_HARTS*NR_SRC_W-1:0] w_set_nxt;
  logic [NR_HARTS*NR_FILES-1:0] w_we_nxt;
  logic [NR_HARTS*NR_SRC_W-1:0] r_setipnum;
  logic [NR_HARTS*NR_FILES-1:0] r_setipnum_we;

  // Only the popped hart's slice carries an identity; all others stay zero.
  always_comb begin
    w_set_nxt = '0;
    w_we_nxt  = '0;
    if (w_pop) begin
      for (int h = 0; h < NR_HARTS; h++) begin
        if (w_head.h == HART_W'(h)) begin
          w_set_nxt[h*NR_SRC_W +: NR_SRC_W] = w_head.id;
          for (int f = 0; f < NR_FILES; f++) begin
            if (w_head.f == FILE_W'(f)) w_we_nxt[h*NR_FILES + f] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_setipnum    <= '0;
      r_setipnum_we <= '0;
    end else begin
      r_setipnum    <= w_set_nxt;
      r_setipnum_we <= w_we_nxt;
    end
  end

  assign o_req_ready   = w_req_ready;
  assign o_rsp_valid   = r_rsp_pending;
  assign o_rsp_err     = r_rsp_err;
  assign o_setipnum    = r_setipnum;
  assign o_setipnum_we = r_setipnum_we;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_imsic_msi_wr_buffer.sv
// Directed, table-driven bench for imsic_msi_wr_buffer (default build and a NR_FILES=3 instance).
module tb_imsic_msi_wr_buffer;

  localparam logic [31:0] M_BASE = 32'h2400_0000;
  localparam logic [31:0] S_BASE = 32'h2800_0000;

`ifdef IMSIC_MSI_BE_EN
  localparam logic [7:0]  BE_WE  = 8'h01;
  localparam logic [23:0] BE_SET = 24'h000007;
`else
  localparam logic [7:0]  BE_WE  = 8'h00;
  localparam logic [23:0] BE_SET = 24'h000000;
`endif

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [3:0]  file_busy;
  logic [23:0] setipnum;
  logic [7:0]  setipnum_we;
  logic [15:0] drop_cnt;

  logic        req_valid3;
  logic        req_ready3;
  logic        rsp_valid3;
  logic        rsp_ready3;
  logic        rsp_err3;
  logic [23:0] setipnum3;
  logic [11:0] setipnum_we3;
  logic [15:0] drop_cnt3;

  imsic_msi_wr_buffer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_err     (rsp_err),
    .i_file_busy   (file_busy),
    .o_setipnum    (setipnum),
    .o_setipnum_we (setipnum_we),
    .o_drop_cnt    (drop_cnt)
  );

  imsic_msi_wr_buffer #(.NR_FILES(3)) dut3 (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid3),
    .o_req_ready   (req_ready3),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_rsp_valid   (rsp_valid3),
    .i_rsp_ready   (rsp_ready3),
    .o_rsp_err     (rsp_err3),
    .i_file_busy   (file_busy),
    .o_setipnum    (setipnum3),
    .o_setipnum_we (setipnum_we3),
    .o_drop_cnt    (drop_cnt3)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_req(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run3(input string name, input logic [31:0] a, input logic [31:0] d,
                      input logic e_err, input logic [11:0] e_we, input logic [23:0] e_set);
    int n;
    n = 0;
    req_addr   = a;
    req_data   = d;
    req_valid3 = 1'b1;
    rsp_ready3 = 1'b1;
    while (!req_ready3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready_wait"}, 32'(req_ready3), 32'd1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    check({name, "_rsp_valid"}, 32'(rsp_valid3), 32'd1);
    check({name, "_rsp_err"}, 32'(rsp_err3), 32'(e_err));
    @(posedge clk); #1;
    check({name, "_we"}, 32'(setipnum_we3), 32'(e_we));
    check({name, "_set"}, 32'(setipnum3), 32'(e_set));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [7:0]  exp_we;
    logic [23:0] exp_set;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vtab[$];
  bit   acc_now;
  bit   accepted;
  int   seen;

  initial begin
    vtab.push_back('{"m_h1",     M_BASE + 32'h1000, 32'd5,          1'b0, 8'h04, 24'h000140, 16'd0});
    vtab.push_back('{"m_h0",     M_BASE,            32'd63,         1'b0, 8'h01, 24'h00003F, 16'd0});
    vtab.push_back('{"m_h3",     M_BASE + 32'h3000, 32'd1,          1'b0, 8'h40, 24'h040000, 16'd0});
    vtab.push_back('{"s_h0",     S_BASE,            32'd10,         1'b0, 8'h02, 24'h00000A, 16'd0});
    vtab.push_back('{"s_h3",     S_BASE + 32'h3000, 32'd9,          1'b0, 8'h80, 24'h240000, 16'd0});
    vtab.push_back('{"m_oob",    M_BASE + 32'h4000, 32'd5,          1'b1, 8'h00, 24'h000000, 16'd0});
    vtab.push_back('{"s_oob",    S_BASE + 32'h4000, 32'd5,          1'b1, 8'h00, 24'h000000, 16'd0});
    vtab.push_back('{"addr0",    32'h0000_0000,     32'd5,          1'b1, 8'h00, 24'h000000, 16'd0});
    vtab.push_back('{"rsvd_off", M_BASE + 32'h1008, 32'd5,          1'b0, 8'h00, 24'h000000, 16'd0});
    vtab.push_back('{"id_zero",  M_BASE,            32'd0,          1'b0, 8'h00, 24'h000000, 16'd1});
    vtab.push_back('{"id_64",    M_BASE + 32'h2000, 32'd64,         1'b0, 8'h00, 24'h000000, 16'd2});
    vtab.push_back('{"id_big",   M_BASE,            32'h0001_0005,  1'b0, 8'h00, 24'h000000, 16'd3});
    vtab.push_back('{"be_off",   M_BASE + 32'h0004, 32'h0700_0000,  1'b0, BE_WE, BE_SET,     16'd3});
    vtab.push_back('{"below_s",  S_BASE - 32'd4,    32'd5,          1'b1, 8'h00, 24'h000000, 16'd3});
    vtab.push_back('{"m_h2",     M_BASE + 32'h2000, 32'd33,         1'b0, 8'h10, 24'h021000, 16'd3});

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    rsp_ready3 = 1'b0;
    file_busy  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_set",       32'(setipnum),  32'd0);
    check("rst_we",        32'(setipnum_we), 32'd0);
    check("rst_drop",      32'(drop_cnt),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Table: accept at E0, strobe visible after E1, cleared after E2.
    for (int i = 0; i < vtab.size(); i++) begin
      rsp_ready = 1'b1;
      send_req(vtab[i].addr, vtab[i].data);
      check({vtab[i].name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({vtab[i].name, "_rsp_err"},   32'(rsp_err),   32'(vtab[i].exp_err));
      @(posedge clk); #1;
      check({vtab[i].name, "_we"},       32'(setipnum_we), 32'(vtab[i].exp_we));
      check({vtab[i].name, "_set"},      32'(setipnum),    32'(vtab[i].exp_set));
      check({vtab[i].name, "_rsp_done"}, 32'(rsp_valid),   32'd0);
      @(posedge clk); #1;
      check({vtab[i].name, "_we_clear"}, 32'(setipnum_we), 32'd0);
      check({vtab[i].name, "_drop"},     32'(drop_cnt),    32'(vtab[i].exp_drop));
    end

    // Response held until consumed; no new request while it is outstanding.
    rsp_ready = 1'b0;
    send_req(M_BASE + 32'h2000, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_rsp_done",  32'(rsp_valid), 32'd0);
    check("hold_ready_back", 32'(req_ready), 32'd1);

    // Back-pressure: hart 0 busy, fill the queue, then release.
    file_busy = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      send_req(M_BASE, 32'(k));
      exp_q.push_back(6'(k));
    end
    @(posedge clk); #1;
    check("bp_full_ready", 32'(req_ready), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (setipnum_we != '0) seen++;
    end
    check("bp_no_strobe_busy", 32'(seen), 32'd0);
    check("bp_still_full", 32'(req_ready), 32'd0);
    exp_q.push_back(6'd5);
    req_addr  = M_BASE;
    req_data  = 32'd5;
    req_valid = 1'b1;
    file_busy = 4'b0000;
    accepted  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      acc_now = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        req_valid = 1'b0;
        accepted  = 1'b1;
      end
      if (setipnum_we != '0) begin
        check("bp_we", 32'(setipnum_we), 32'h01);
        if (exp_q.size() == 0) check("bp_extra_strobe", 32'(setipnum[5:0]), 32'hFFFF_FFFF);
        else                   check("bp_order", 32'(setipnum[5:0]), 32'(exp_q.pop_front()));
      end
    end
    req_valid = 1'b0;
    check("bp_5th_accepted", 32'(accepted), 32'd1);
    check("bp_all_drained", 32'(exp_q.size()), 32'd0);

    // NR_FILES=3 instance: S group decode with two files per hart.
    run3("g3_s_h1f2", S_BASE + 32'h3000, 32'd9, 1'b0, 12'h020, 24'h000240);
    run3("g3_s_h3f2", S_BASE + 32'h7000, 32'd3, 1'b0, 12'h800, 24'h0C0000);
    run3("g3_s_oob",  S_BASE + 32'h8000, 32'd3, 1'b1, 12'h000, 24'h000000);

    // Reset with two entries queued and a response pending.
    file_busy = 4'b0001;
    rsp_ready = 1'b1;
    send_req(M_BASE, 32'd11);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_req(M_BASE, 32'd12);
    check("mid_rsp_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp",   32'(rsp_valid), 32'd0);
    check("mid_rst_err",   32'(rsp_err),   32'd0);
    check("mid_rst_set",   32'(setipnum),  32'd0);
    check("mid_rst_we",    32'(setipnum_we), 32'd0);
    check("mid_rst_drop",  32'(drop_cnt),  32'd0);
    rst       = 1'b0;
    file_busy = 4'b0000;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (setipnum_we != '0) seen++;
    end
    check("mid_no_strobe", 32'(seen), 32'd0);
    check("mid_rsp_idle",  32'(rsp_valid), 32'd0);
    check("mid_ready",     32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/imsic_msi_wr_buffer.md
# imsic_msi_wr_buffer

Buffered, parameterised MSI write decoder for the IMSIC. It sits between the bus-side write slave and the per-hart interrupt files, covering M-level and S/guest-level files for NR_HARTS harts. It decodes each MSI write into a (hart, file, identity) triple and queues it in a FIFO. Entries drain to the files under per-hart back-pressure, with bus responses and error reporting handled in the block.

## Interface
Parameters:
- NR_HARTS, 4, number of harts
- NR_FILES, 2, interrupt files per hart; file 0 = M, files 1..NR_FILES-1 = S + guests
- NR_SRC, 64, number of identities per file; identity width NR_SRC_W = $clog2(NR_SRC)
- ADDR_W, 32, request address width
- M_BASE, 32'h2400_0000, base of M-file pages (one 4 KiB page per hart)
- S_BASE, 32'h2800_0000, base of S-group pages, page index = h*(NR_FILES-1) + (f-1)
- FIFO_DEPTH, 4, decoded-MSI queue depth (power of two, ≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  write request valid
- o_req_ready  out  1  write request accepted when both high
- i_req_addr  in  ADDR_W  byte address
- i_req_data  in  32  write data
- o_rsp_valid  out  1  write response valid
- i_rsp_ready  in  1  response consumed
- o_rsp_err  out  1  1 = SLVERR (address outside all pages)
- i_file_busy  in  NR_HARTS  per-hart file cannot accept a setipnum this cycle
- o_setipnum  out  NR_HARTS*NR_SRC_W  identity per hart, slice h
- o_setipnum_we  out  NR_HARTS*NR_FILES  one-cycle strobe, bit h*NR_FILES+f
- o_drop_cnt  out  16  saturating count of MSIs dropped for invalid identity

## Operation
- Decode, per accepted request:
  - M page: addr in [M_BASE, M_BASE+NR_HARTS*0x1000); h = page index; f = 0.
  - S page: addr in [S_BASE, S_BASE+NR_HARTS*(NR_FILES-1)*0x1000); p = page index; h = p/(NR_FILES-1); f = p%(NR_FILES-1)+1.
  - Any other address: error response; nothing enqueued.
- Within a valid page:
  - Offset 0x000 (seteipnum_le): identity = i_req_data.
  - Offset 0x004 (seteipnum_be): identity = byte-swapped data, only when IMSIC_MSI_BE_EN is defined.
  - All other offsets: OKAY response; nothing enqueued.
- Identity check: identity == 0 or identity ≥ NR_SRC (full 32-bit compare) → OKAY response, no enqueue, o_drop_cnt += 1, saturating at 16'hFFFF.
- Valid identity: push {h, f, identity[NR_SRC_W-1:0]} into the FIFO.
- Responses: at most one outstanding. The response is held until i_rsp_ready.
- Drain:
  - The head entry pops when the FIFO is non-empty and i_file_busy[head.h] == 0. No reordering: head-of-line blocking is intended.
  - Pop loads the output registers: slice h of o_setipnum and strobe bit h*NR_FILES+f for one cycle.
  - All other strobes are 0. Other o_setipnum slices are 0 when not strobed.
- Reset: FIFO empty, pointers 0. o_req_ready=0 during reset and 1 in the first cycle after. o_rsp_valid=0, o_rsp_err=0, o_setipnum='0, o_setipnum_we='0, o_drop_cnt=0. A request or response in flight at reset is discarded.

## Timing
- o_req_ready = !rsp_pending && !fifo_full. This is a registered-state function with no combinational path from i_req_valid.
- A request accepted at edge E0 gives o_rsp_valid high from E0 until the edge where i_rsp_ready is sampled high. The next request can be accepted in that same edge's following cycle.
- Enqueue happens at E0. The earliest pop is at E1, and the o_setipnum_we strobe is high between E1 and E2. Minimum accept→strobe latency is 1 cycle, sustained throughput 1 MSI per 2 cycles (response-limited).
- Push and pop in the same cycle are allowed. When full, ready is already 0, so there is no bypass.
- Pointer wrap is modulo FIFO_DEPTH; a count register distinguishes full from empty.
- A busy hart only stalls the head. Accepting new requests continues until the FIFO is full.

## Configuration
- IMSIC_MSI_BE_EN defined: offset 0x004 is decoded as seteipnum_be, and identity = {data[7:0],data[15:8],data[23:16],data[31:24]}.
- IMSIC_MSI_BE_EN undefined: offset 0x004 is treated like any other reserved offset (OKAY, no enqueue, no drop count).

## Test plan
- LE M write: addr M_BASE+0x1000, data 5 → OKAY. Next cycle o_setipnum_we bit 2 (h1,f0) pulses once with o_setipnum slice 1 = 5.
- S group (NR_FILES=3): addr S_BASE+3*0x1000, data 9 → h1,f2. Strobe bit 5, slice 1 = 9.
- Errors and drops:
  - addr M_BASE+4*0x1000 → o_rsp_err=1, no strobe.
  - data 0 or 64 → OKAY, no strobe, o_drop_cnt increments to 1 then 2.
- Back-pressure: hold i_file_busy[0]=1 and send 5 writes to hart 0. After 4 accepts o_req_ready=0. Release busy: 4 strobes in order, then the 5th is accepted.
- BE (macro on): addr M_BASE+0x004, data 32'h0700_0000 → identity 7 on hart 0. Macro off: no strobe, OKAY.
- Reset mid-operation: assert i_rst with 2 entries queued and a response pending. Next cycle all outputs are 0, and no strobe occurs after reset release.
